mcs_io_slave: RTL and testbench

IO-bus slave that sits directly downstream of the MicroBlaze MCS IO bus (IO_Addr_Strobe/IO_Ready protocol) in the SATA core. It decodes each MCS IO access into a small local register bank or a forwarded request on a generic register port toward the SATA link/transport registers. It returns exactly one IO_Ready per accepted access and bounds every external access with a timeout so firmware never hangs.

---
 rtl/mcs_io_pkg.sv | 31 +++
 rtl/mcs_io_timeout.sv | 28 ++
 rtl/mcs_io_slave.sv | 178 +++++++++++++++++
 tb/tb_mcs_io_slave.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs_io_pkg.sv
// Shared types and constants for the MCS IO-bus slave: FSM states, local offsets,
// external window bounds and the read-error pattern.
package mcs_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCAL = 2'd1,
        ST_EXT   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] OFF_ID      = 16'h0000;
    localparam logic [15:0] OFF_SCRATCH = 16'h0004;
    localparam logic [15:0] OFF_ERRCNT  = 16'h0008;
    localparam logic [15:0] OFF_ERRADDR = 16'h000C;
    localparam logic [15:0] EXT_LO      = 16'h1000;
    localparam logic [15:0] EXT_HI      = 16'h1FFF;

    localparam logic [31:0] DEADBEEF    = 32'hDEAD_BEEF;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mcs_io_timeout.sv
// Wait-cycle counter for external accesses; o_expire flags the last allowed cycle.
module mcs_io_timeout #(
    parameter int unsigned C_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);

    localparam logic [15:0] C_LAST = 16'(C_TIMEOUT - 1);

    logic [15:0] r_cnt;

    // Counter holds at the last value so o_expire stays a clean level until reload.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= '0;
        else if (i_run && !o_expire)
            r_cnt <= r_cnt + 16'd1;
    end

    assign o_expire = (r_cnt == C_LAST);

endmodule

// File: rtl/mcs_io_slave.sv
// MicroBlaze MCS IO-bus slave: local ID/scratch/error registers plus a forwarded,
// timeout-bounded register port toward the SATA link/transport registers.
module mcs_io_slave
    import mcs_io_pkg::*;
#(
    parameter logic [31:0] C_BASE    = 32'hC000_0000,
    parameter logic [31:0] C_ID      = 32'h5341_0100,
    parameter int unsigned C_TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IO_Addr_Strobe,
    input  logic        IO_Read_Strobe,
    input  logic        IO_Write_Strobe,
    input  logic [31:0] IO_Address,
    input  logic [3:0]  IO_Byte_Enable,
    input  logic [31:0] IO_Write_Data,
    output logic [31:0] IO_Read_Data,
    output logic        IO_Ready,
    output logic        reg_req,
    output logic        reg_we,
    output logic [9:0]  reg_addr,
    output logic [3:0]  reg_be,
    output logic [31:0] reg_wdata,
    input  logic        reg_ack,
    input  logic [31:0] reg_rdata,
    output logic        err_irq
);

    state_t      r_state, w_next;

    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_req;
    logic        r_we;
    logic [9:0]  r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_acc_addr;
    logic [31:0] r_scratch;
    logic [15:0] r_errcnt;
    logic [31:0] r_erraddr;

    logic [15:0] w_off;
    logic        w_in_win, w_ext, w_hit, w_we;
    logic        w_accept, w_ack, w_expire, w_tmo;
    logic        w_err, w_cnt_clr;
    logic [31:0] w_err_addr;
    logic [31:0] w_local_rd;
    logic        w_unused;

    // Read strobe is implied: anything that is not a write is a read.
    assign w_unused = IO_Read_Strobe;

    assign w_off    = IO_Address[15:0];
    assign w_in_win = (IO_Address[31:16] == C_BASE[31:16]);
    assign w_ext    = w_in_win && (w_off >= EXT_LO) && (w_off <= EXT_HI);
    assign w_hit    = w_in_win && ((w_off == OFF_ID) || (w_off == OFF_SCRATCH) ||
                                   (w_off == OFF_ERRCNT) || (w_off == OFF_ERRADDR));
    assign w_we     = IO_Write_Strobe;

    assign w_accept = (r_state == ST_IDLE) && IO_Addr_Strobe;
    assign w_ack    = (r_state == ST_EXT) && reg_ack;
    assign w_tmo    = (r_state == ST_EXT) && !reg_ack && w_expire;

    assign w_cnt_clr  = w_accept && w_we && w_in_win && (w_off == OFF_ERRCNT);
    assign w_err      = (w_accept && !w_ext && !w_hit) || w_tmo;
    assign w_err_addr = w_tmo ? r_acc_addr : IO_Address;

    always_comb begin
        w_local_rd = '0;
        if (w_hit) begin
            case (w_off)
                OFF_ID:      w_local_rd = C_ID;
                OFF_SCRATCH: w_local_rd = r_scratch;
                OFF_ERRCNT:  w_local_rd = {16'h0000, r_errcnt};
                OFF_ERRADDR: w_local_rd = r_erraddr;
                default:     w_local_rd = '0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (IO_Addr_Strobe) w_next = w_ext ? ST_EXT : ST_LOCAL;
            ST_LOCAL: w_next = ST_IDLE;
            ST_EXT:   if (reg_ack || w_expire) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    mcs_io_timeout #(.C_TIMEOUT(C_TIMEOUT)) u_timeout (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_load   (w_accept && w_ext),
        .i_run    (r_state == ST_EXT),
        .o_expire (w_expire)
    );

    // Ready and read data are single-cycle pulses; data is forced to 0 otherwise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_acc_addr <= '0;
        end else begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            if (w_accept) begin
                if (w_ext) begin
                    r_req      <= 1'b1;
                    r_we       <= w_we;
                    r_addr     <= IO_Address[11:2];
                    r_be       <= IO_Byte_Enable;
                    r_wdata    <= IO_Write_Data;
                    r_acc_addr <= IO_Address;
                end else begin
                    r_ready <= 1'b1;
                    if (!w_we) r_rdata <= w_local_rd;
                end
            end
            if (w_ack) begin
                r_req   <= 1'b0;
                r_ready <= 1'b1;
                if (!r_we) r_rdata <= reg_rdata;
            end
            if (w_tmo) begin
                r_req   <= 1'b0;
                r_ready <= 1'b1;
                if (!r_we) r_rdata <= DEADBEEF;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            r_scratch <= '0;
        else if (w_accept && w_we && w_in_win && (w_off == OFF_SCRATCH))
            r_scratch <= be_merge(r_scratch, IO_Write_Data, IO_Byte_Enable);
    end

    // A clear-write and an error never share a cycle: only one access is in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_errcnt  <= '0;
            r_erraddr <= '0;
        end else if (w_err) begin
            if (r_errcnt != 16'hFFFF) r_errcnt <= r_errcnt + 16'd1;
            r_erraddr <= w_err_addr;
        end else if (w_cnt_clr) begin
            r_errcnt <= '0;
        end
    end

    assign IO_Ready     = r_ready;
    assign IO_Read_Data = r_rdata;
    assign reg_req      = r_req;
    assign reg_we       = r_we;
    assign reg_addr     = r_addr;
    assign reg_be       = r_be;
    assign reg_wdata    = r_wdata;
    assign err_irq      = (r_errcnt != 16'h0000);

endmodule

// File: tb/tb_mcs_io_slave.sv
// Scoreboard bench for mcs_io_slave: expected read data queued per access and
// popped by a monitor on every IO_Ready; feature tasks check latency and side effects.
module tb_mcs_io_slave;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe;
    logic [31:0] IO_Address, IO_Write_Data;
    logic [3:0]  IO_Byte_Enable;
    logic [31:0] IO_Read_Data;
    logic        IO_Ready;
    logic        reg_req, reg_we;
    logic [9:0]  reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        err_irq;

    mcs_io_slave #(
        .C_BASE    (32'hC000_0000),
        .C_ID      (32'h5341_0100),
        .C_TIMEOUT (8)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .IO_Addr_Strobe  (IO_Addr_Strobe),
        .IO_Read_Strobe  (IO_Read_Strobe),
        .IO_Write_Strobe (IO_Write_Strobe),
        .IO_Address      (IO_Address),
        .IO_Byte_Enable  (IO_Byte_Enable),
        .IO_Write_Data   (IO_Write_Data),
        .IO_Read_Data    (IO_Read_Data),
        .IO_Ready        (IO_Ready),
        .reg_req         (reg_req),
        .reg_we          (reg_we),
        .reg_addr        (reg_addr),
        .reg_be          (reg_be),
        .reg_wdata       (reg_wdata),
        .reg_ack         (reg_ack),
        .reg_rdata       (reg_rdata),
        .err_irq         (err_irq)
    );

    always #5 Clk = ~Clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb[$];

    int          ack_dly = -1;
    logic [31:0] ack_data = '0;
    int          cur_len = 0;
    int          last_len = 0;
    logic [9:0]  seen_addr;
    logic        seen_we;
    logic [3:0]  seen_be;
    logic [31:0] seen_wd;
    logic        seen_stable;
    logic [31:0] exp_scratch = '0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic bus_op(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, output int lat);
        @(posedge Clk); #1;
        IO_Addr_Strobe = 1'b1; IO_Write_Strobe = wr; IO_Read_Strobe = rd;
        IO_Address = addr; IO_Byte_Enable = be; IO_Write_Data = wd;
        @(posedge Clk); #1;
        IO_Addr_Strobe = 1'b0; IO_Write_Strobe = 1'b0; IO_Read_Strobe = 1'b0;
        lat = 1;
        while (IO_Ready !== 1'b1 && lat < 100) begin
            @(posedge Clk); #1; lat++;
        end
        if (IO_Ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout addr=%h waited %0d cycles", addr, lat);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        vectors++;
        if ({IO_Ready, IO_Read_Data, reg_req, reg_we, reg_addr, reg_be, reg_wdata, err_irq} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got rdy=%b rd=%h req=%b we=%b a=%h be=%h wd=%h irq=%b want all 0",
                     IO_Ready, IO_Read_Data, reg_req, reg_we, reg_addr, reg_be, reg_wdata, err_irq);
        end
        Reset = 1'b0;
    endtask

    task automatic test_id();
        int lat;
        sb.push_back(32'h0000_0000); bus_op(0, 1, 32'hC000_0008, 4'hF, 0, lat);
        sb.push_back(32'h0000_0000); bus_op(0, 1, 32'hC000_0004, 4'hF, 0, lat);
        sb.push_back(32'h0000_0000); bus_op(0, 1, 32'hC000_000C, 4'hF, 0, lat);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(32'h5341_0100);
            bus_op(0, 1, 32'hC000_0000, 4'hF, 0, lat);
            vectors++;
            if (lat !== 1) begin
                miscompares++;
                $display("FAIL id_latency[%0d] got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_scratch();
        int lat;
        sb.push_back(0); bus_op(1, 0, 32'hC000_0004, 4'b0101, 32'hAABB_CCDD, lat);
        exp_scratch = merge(exp_scratch, 32'hAABB_CCDD, 4'b0101);
        sb.push_back(32'h00BB_00DD); bus_op(0, 1, 32'hC000_0004, 4'hF, 0, lat);
        sb.push_back(0); bus_op(1, 0, 32'hC000_0004, 4'b1010, 32'h1122_3344, lat);
        exp_scratch = merge(exp_scratch, 32'h1122_3344, 4'b1010);
        sb.push_back(exp_scratch); bus_op(0, 1, 32'hC000_0004, 4'hF, 0, lat);
        // ID is read-only
        sb.push_back(0); bus_op(1, 0, 32'hC000_0000, 4'hF, 32'hFFFF_FFFF, lat);
        sb.push_back(32'h5341_0100); bus_op(0, 1, 32'hC000_0000, 4'hF, 0, lat);
    endtask

    task automatic test_ext();
        int lat;
        ack_dly = 5; ack_data = 32'h1234_5678;
        sb.push_back(32'h1234_5678);
        bus_op(0, 1, 32'hC000_1010, 4'hF, 0, lat);
        vectors++;
        if (lat !== 7 || seen_addr !== 10'h004 || seen_we !== 1'b0 || seen_stable !== 1'b1) begin
            miscompares++;
            $display("FAIL ext_read got lat=%0d addr=%h we=%b stable=%b want 7 004 0 1",
                     lat, seen_addr, seen_we, seen_stable);
        end
        ack_dly = 0; ack_data = 32'hCAFE_F00D;
        sb.push_back(32'hCAFE_F00D);
        bus_op(0, 1, 32'hC000_1FFC, 4'hF, 0, lat);
        vectors++;
        if (lat !== 2 || seen_addr !== 10'h3FF) begin
            miscompares++;
            $display("FAIL ext_min_latency got lat=%0d addr=%h want 2 3ff", lat, seen_addr);
        end
        ack_dly = 2; ack_data = 32'hFFFF_FFFF;
        sb.push_back(0);
        bus_op(1, 0, 32'hC000_1000, 4'b0011, 32'h0000_55AA, lat);
        vectors++;
        if (lat !== 4 || seen_we !== 1'b1 || seen_be !== 4'b0011 || seen_wd !== 32'h55AA ||
            seen_addr !== 10'h000 || err_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_write got lat=%0d we=%b be=%b wd=%h a=%h irq=%b want 4 1 0011 55aa 000 0",
                     lat, seen_we, seen_be, seen_wd, seen_addr, err_irq);
        end
    endtask

    task automatic test_timeout();
        int lat;
        ack_dly = -1;
        sb.push_back(0);
        bus_op(1, 0, 32'hC000_1234, 4'hF, 32'h0BAD_0BAD, lat);
        vectors++;
        if (lat !== 9 || err_irq !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_write got lat=%0d irq=%b want 9 1", lat, err_irq);
        end
        @(posedge Clk); #1;
        vectors++;
        if (last_len !== 8) begin
            miscompares++;
            $display("FAIL tmo_req_len got %0d want 8", last_len);
        end
        sb.push_back(32'd1);          bus_op(0, 1, 32'hC000_0008, 4'hF, 0, lat);
        sb.push_back(32'hC000_1234);  bus_op(0, 1, 32'hC000_000C, 4'hF, 0, lat);
        sb.push_back(32'hDEAD_BEEF);  bus_op(0, 1, 32'hC000_1800, 4'hF, 0, lat);
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL tmo_read_latency got %0d want 9", lat);
        end
        sb.push_back(32'd2);          bus_op(0, 1, 32'hC000_0008, 4'hF, 0, lat);
    endtask

    task automatic test_unmapped();
        int lat;
        sb.push_back(0);             bus_op(0, 1, 32'hB000_0000, 4'hF, 0, lat);
        sb.push_back(32'd3);         bus_op(0, 1, 32'hC000_0008, 4'hF, 0, lat);
        sb.push_back(32'hB000_0000); bus_op(0, 1, 32'hC000_000C, 4'hF, 0, lat);
        sb.push_back(0);             bus_op(1, 0, 32'hC000_0010, 4'hF, 32'h1, lat);
        sb.push_back(0);             bus_op(0, 1, 32'hC000_2000, 4'hF, 0, lat);
        sb.push_back(32'd5);         bus_op(0, 1, 32'hC000_0008, 4'hF, 0, lat);
        sb.push_back(32'hC000_2000); bus_op(0, 1, 32'hC000_000C, 4'hF, 0, lat);
        sb.push_back(0);             bus_op(1, 0, 32'hC000_0008, 4'b0001, 0, lat);
        vectors++;
        if (err_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL errcnt_clear_irq got %b want 0", err_irq);
        end
        sb.push_back(0);             bus_op(0, 1, 32'hC000_0008, 4'hF, 0, lat);
        sb.push_back(exp_scratch);   bus_op(0, 1, 32'hC000_0004, 4'hF, 0, lat);
    endtask

    task automatic test_ack_at_timeout();
        int lat;
        ack_dly = 7; ack_data = 32'h0BAD_CAFE;
        sb.push_back(32'h0BAD_CAFE);
        bus_op(0, 1, 32'hC000_1004, 4'hF, 0, lat);
        vectors++;
        if (lat !== 9 || err_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_at_timeout got lat=%0d irq=%b want 9 0", lat, err_irq);
        end
        sb.push_back(0); bus_op(0, 1, 32'hC000_0008, 4'hF, 0, lat);
    endtask

    task automatic test_strobes();
        int lat;
        sb.push_back(0); bus_op(1, 1, 32'hC000_0004, 4'hF, 32'h5A5A_A5A5, lat);
        exp_scratch = 32'h5A5A_A5A5;
        sb.push_back(exp_scratch); bus_op(0, 0, 32'hC000_0004, 4'hF, 32'h0, lat);
    endtask

    task automatic test_busy();
        int lat;
        ack_dly = 3; ack_data = 32'h7777_0001;
        sb.push_back(32'h7777_0001);
        @(posedge Clk); #1;
        IO_Addr_Strobe = 1; IO_Read_Strobe = 1; IO_Write_Strobe = 0; IO_Address = 32'hC000_1008;
        @(posedge Clk); #1;
        IO_Addr_Strobe = 0; IO_Read_Strobe = 0;
        @(posedge Clk); #1;
        IO_Addr_Strobe = 1; IO_Write_Strobe = 1; IO_Address = 32'hC000_0004;
        IO_Byte_Enable = 4'hF; IO_Write_Data = 32'hFFFF_FFFF;
        @(posedge Clk); #1;
        IO_Addr_Strobe = 0; IO_Write_Strobe = 0;
        lat = 3;
        while (IO_Ready !== 1'b1 && lat < 50) begin @(posedge Clk); #1; lat++; end
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL busy_ext_latency got %0d want 5", lat);
        end
        repeat (4) @(posedge Clk);
        sb.push_back(exp_scratch); bus_op(0, 1, 32'hC000_0004, 4'hF, 0, lat);
    endtask

    task automatic test_reset_mid_ext();
        int lat, rdy;
        sb.push_back(0); bus_op(0, 1, 32'hC000_0000 + 32'hB0, 4'hF, 0, lat);
        ack_dly = -1;
        @(posedge Clk); #1;
        IO_Addr_Strobe = 1; IO_Read_Strobe = 1; IO_Address = 32'hC000_1100;
        @(posedge Clk); #1;
        IO_Addr_Strobe = 0; IO_Read_Strobe = 0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        vectors++;
        if (reg_req !== 1'b0 || IO_Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_ext got req=%b rdy=%b want 0 0", reg_req, IO_Ready);
        end
        Reset = 1'b0;
        rdy = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge Clk); #1;
            if (IO_Ready === 1'b1) rdy++;
        end
        vectors++;
        if (rdy !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_ext_no_ready got %0d readies want 0", rdy);
        end
        exp_scratch = 0;
        sb.push_back(32'h5341_0100); bus_op(0, 1, 32'hC000_0000, 4'hF, 0, lat);
        sb.push_back(0);             bus_op(0, 1, 32'hC000_0008, 4'hF, 0, lat);
        sb.push_back(exp_scratch);   bus_op(0, 1, 32'hC000_0004, 4'hF, 0, lat);
    endtask

    initial begin
        Reset = 1'b1;
        IO_Addr_Strobe = 0; IO_Read_Strobe = 0; IO_Write_Strobe = 0;
        IO_Address = 0; IO_Byte_Enable = 0; IO_Write_Data = 0;
        reg_ack = 0; reg_rdata = 0;
        seen_addr = 0; seen_we = 0; seen_be = 0; seen_wd = 0; seen_stable = 0;

        fork
            // external register responder
            forever begin
                @(posedge Clk); #1;
                reg_ack = 1'b0;
                if (reg_req === 1'b1) begin
                    if (cur_len == 0) begin
                        seen_addr = reg_addr; seen_we = reg_we; seen_be = reg_be;
                        seen_wd = reg_wdata; seen_stable = 1'b1;
                    end else if ({reg_addr, reg_we, reg_be, reg_wdata} !==
                                 {seen_addr, seen_we, seen_be, seen_wd}) begin
                        seen_stable = 1'b0;
                    end
                    if (cur_len == ack_dly) begin
                        reg_ack = 1'b1; reg_rdata = ack_data;
                    end
                    cur_len++;
                end else if (cur_len != 0) begin
                    last_len = cur_len; cur_len = 0;
                end
            end
            // completion monitor
            forever begin
                @(negedge Clk);
                if (Reset === 1'b0) begin
                    if (IO_Ready === 1'b1) begin
                        vectors++;
                        if (sb.size() == 0) begin
                            miscompares++;
                            $display("FAIL unexpected_ready data=%h at %0t", IO_Read_Data, $time);
                        end else begin
                            logic [31:0] e;
                            e = sb.pop_front();
                            if (IO_Read_Data !== e) begin
                                miscompares++;
                                $display("FAIL read_data got %h want %h at %0t", IO_Read_Data, e, $time);
                            end
                        end
                    end else if (IO_Read_Data !== 32'h0) begin
                        miscompares++;
                        $display("FAIL idle_data got %h want 0 at %0t", IO_Read_Data, $time);
                    end
                end
            end
        join_none

        test_reset();
        test_id();
        test_scratch();
        test_ext();
        test_timeout();
        test_unmapped();
        test_ack_at_timeout();
        test_strobes();
        test_busy();
        test_reset_mid_ext();

        repeat (3) @(posedge Clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
